// File: rtl/bch_syndrome_collect_if.sv
// rtl/bch_syndrome_collect_if.sv - handshake bundle between syndrome counters, collector and BM stage
//
// Purpose: groups the parallel syndrome input, the per-beat syndrome stream
// and the overflow flag of bch_syndrome_collect.
// Parameters: pT (correction capability, 2*pT syndromes), pM (GF(2^m) width).
// Signals:
//   isyndrome_val  one-cycle pulse, isyndrome valid
//   isyndrome      2*pT*pM bits, S1 in [pM-1:0], S_j in [j*pM-1 -: pM]
//   irdy           downstream ready
//   oval           osyndrome valid
//   osop / oeop    first / last beat of a frame
//   osyndrome      current syndrome
//   ozero          frame is all-zero
//   ooverflow      one-cycle pulse, incoming frame dropped
// Modports: slave = collector side, master = upstream/downstream environment.

interface bch_syndrome_collect_if #(
   parameter int pT = 8,
   parameter int pM = 13
);
   logic                  isyndrome_val;
   logic [2*pT*pM-1:0]    isyndrome;
   logic                  irdy;
   logic                  oval;
   logic                  osop;
   logic                  oeop;
   logic [pM-1:0]         osyndrome;
   logic                  ozero;
   logic                  ooverflow;

   modport slave (
      input  isyndrome_val, isyndrome, irdy,
      output oval, osop, oeop, osyndrome, ozero, ooverflow
   );

   modport master (
      output isyndrome_val, isyndrome, irdy,
      input  oval, osop, oeop, osyndrome, ozero, ooverflow
   );
endinterface

// File: rtl/bch_syndrome_collect.sv
// rtl/bch_syndrome_collect.sv - two-slot syndrome buffer streaming one syndrome per beat to the BM stage
//
// Purpose: captures all 2*pT syndromes of a codeword in one cycle, holds up
// to two frames (ping-pong) and serialises them as a valid/ready stream with
// sop/eop framing and an all-zero flag. A third frame arriving while both
// slots are occupied and none is freed that cycle is dropped (ooverflow).
// Ports:
//   iclk      clock
//   ireset_n  asynchronous active-low reset
//   bus       bch_syndrome_collect_if.slave (see interface for signals)
// Optional feature macro: BCH_SYNDROME_COLLECT_ZERO_SKIP_EN
//   defined   - an all-zero frame is emitted as a single sop+eop beat
//   undefined - every frame is emitted as the full 2*pT beats
// All outputs are registered; irdy only feeds next-state logic.

module bch_syndrome_collect #(
   parameter int pT = 8,
   parameter int pM = 13
) (
   input  logic                         iclk,
   input  logic                         ireset_n,
   bch_syndrome_collect_if.slave        bus
);

   localparam int NB = 2 * pT;
   localparam int W  = NB * pM;
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [IW-1:0] LAST = IW'(NB - 1);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t             state, state_nxt;
   logic [IW-1:0]      idx, idx_nxt;
   logic [1:0]         count, count_nxt;
   logic               wptr, wptr_nxt;
   logic               rptr, rptr_nxt;
   logic [1:0][W-1:0]  slot_data, data_nxt;
   logic [1:0]         slot_zero, zero_nxt;

   logic               oval_q, osop_q, oeop_q, ozero_q, ooverflow_q;
   logic [pM-1:0]      osyndrome_q;
   logic               oval_nxt, osop_nxt, oeop_nxt, ozero_nxt, ooverflow_nxt;
   logic [pM-1:0]      osyndrome_nxt;

   logic               fire, last, free, wr;
   logic [W-1:0]       cur;

   always_comb begin
      state_nxt     = state;
      idx_nxt       = idx;
      wptr_nxt      = wptr;
      rptr_nxt      = rptr;
      data_nxt      = slot_data;
      zero_nxt      = slot_zero;
      oval_nxt      = 1'b0;
      osop_nxt      = 1'b0;
      oeop_nxt      = 1'b0;
      ozero_nxt     = 1'b0;
      osyndrome_nxt = '0;
      cur           = '0;

      // oval_q is high exactly while the FSM is in STREAM
      fire = oval_q & bus.irdy;
`ifdef BCH_SYNDROME_COLLECT_ZERO_SKIP_EN
      last = (idx == LAST) | slot_zero[rptr];
`else
      last = (idx == LAST);
`endif
      free = fire & last;

      // a full buffer still accepts when its read slot is released this cycle;
      // in that case wptr == rptr, so the new frame reuses the freed slot
      wr            = bus.isyndrome_val & ((count != 2'd2) | free);
      ooverflow_nxt = bus.isyndrome_val & ~wr;

      if (wr) begin
         data_nxt[wptr] = bus.isyndrome;
         zero_nxt[wptr] = ~|bus.isyndrome;
         wptr_nxt       = ~wptr;
      end
      if (free) begin
         rptr_nxt = ~rptr;
      end
      count_nxt = count + 2'(wr) - 2'(free);

      case (state)
         IDLE: begin
            idx_nxt = '0;
            if (count_nxt != 2'd0) begin
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            if (free) begin
               idx_nxt   = '0;
               state_nxt = (count_nxt != 2'd0) ? STREAM : IDLE;
            end else if (fire) begin
               idx_nxt = idx + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            idx_nxt   = '0;
         end
      endcase

      // outputs are computed from next-state values so a frame written into
      // an empty buffer is already presented on the following cycle
      if (state_nxt == STREAM) begin
         cur           = data_nxt[rptr_nxt];
         oval_nxt      = 1'b1;
         osyndrome_nxt = cur[idx_nxt * pM +: pM];
         osop_nxt      = (idx_nxt == '0);
         ozero_nxt     = zero_nxt[rptr_nxt];
`ifdef BCH_SYNDROME_COLLECT_ZERO_SKIP_EN
         oeop_nxt      = (idx_nxt == LAST) | zero_nxt[rptr_nxt];
`else
         oeop_nxt      = (idx_nxt == LAST);
`endif
      end
   end

   always_ff @(posedge iclk or negedge ireset_n) begin
      if (!ireset_n) begin
         state       <= IDLE;
         idx         <= '0;
         count       <= '0;
         wptr        <= 1'b0;
         rptr        <= 1'b0;
         slot_data   <= '0;
         slot_zero   <= '0;
         oval_q      <= 1'b0;
         osop_q      <= 1'b0;
         oeop_q      <= 1'b0;
         ozero_q     <= 1'b0;
         ooverflow_q <= 1'b0;
         osyndrome_q <= '0;
      end else begin
         state       <= state_nxt;
         idx         <= idx_nxt;
         count       <= count_nxt;
         wptr        <= wptr_nxt;
         rptr        <= rptr_nxt;
         slot_data   <= data_nxt;
         slot_zero   <= zero_nxt;
         oval_q      <= oval_nxt;
         osop_q      <= osop_nxt;
         oeop_q      <= oeop_nxt;
         ozero_q     <= ozero_nxt;
         ooverflow_q <= ooverflow_nxt;
         osyndrome_q <= osyndrome_nxt;
      end
   end

   assign bus.oval      = oval_q;
   assign bus.osop      = osop_q;
   assign bus.oeop      = oeop_q;
   assign bus.ozero     = ozero_q;
   assign bus.ooverflow = ooverflow_q;
   assign bus.osyndrome = osyndrome_q;

endmodule

// File: tb/tb_bch_syndrome_collect.sv
// tb/tb_bch_syndrome_collect.sv - scoreboard bench for bch_syndrome_collect (pT=2, pM=4)

module tb_bch_syndrome_collect;

   localparam int PT = 2;
   localparam int PM = 4;

   logic iclk = 1'b0;
   logic ireset_n = 1'b0;

   bch_syndrome_collect_if #(.pT(PT), .pM(PM)) bus ();

   bch_syndrome_collect #(.pT(PT), .pM(PM)) dut (
      .iclk     (iclk),
      .ireset_n (ireset_n),
      .bus      (bus.slave)
   );

   always #5 iclk = ~iclk;

   int tests = 0;
   int fails = 0;

   // expected beat: {syndrome[3:0], sop, eop, zero}
   logic [6:0] q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_frame(input logic [15:0] d);
`ifdef BCH_SYNDROME_COLLECT_ZERO_SKIP_EN
      if (d == 16'h0) begin
         q.push_back({4'h0, 1'b1, 1'b1, 1'b1});
         return;
      end
`endif
      for (int j = 0; j < 2 * PT; j++) begin
         q.push_back({d[j*PM +: PM], j == 0, j == 2 * PT - 1, d == 16'h0});
      end
   endtask

   task automatic tick();
      @(posedge iclk);
      #1;
   endtask

   task automatic send(input logic [15:0] d, input logic expect_accept);
      bus.isyndrome_val = 1'b1;
      bus.isyndrome     = d;
      if (expect_accept) push_frame(d);
      tick();
      bus.isyndrome_val = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((q.size() != 0 || bus.oval) && n < 60) begin
         tick();
         n++;
      end
      check(tag, n < 60, 1'b1);
   endtask

   // scoreboard: every transferred beat is compared with the next expected one
   always @(negedge iclk) begin
      if (ireset_n && bus.oval && bus.irdy) begin
         tests++;
         assert (q.size() > 0) else begin
            fails++;
            $error("FAIL unexpected_beat: observed %0h expected none", bus.osyndrome);
         end
         if (q.size() > 0) begin
            check("beat", {bus.osyndrome, bus.osop, bus.oeop, bus.ozero}, q.pop_front());
         end
      end
   end

   initial begin
      logic found;
      bus.isyndrome_val = 1'b0;
      bus.isyndrome     = '0;
      bus.irdy          = 1'b0;

      // reset with random inputs
      for (int i = 0; i < 4; i++) begin
         bus.isyndrome_val = 1'($urandom_range(0, 1));
         bus.isyndrome     = 16'($urandom);
         bus.irdy          = 1'($urandom_range(0, 1));
         tick();
      end
      check("rst_oval", bus.oval, 0);
      check("rst_osop", bus.osop, 0);
      check("rst_oeop", bus.oeop, 0);
      check("rst_ozero", bus.ozero, 0);
      check("rst_ooverflow", bus.ooverflow, 0);
      check("rst_osyndrome", bus.osyndrome, 0);
      bus.isyndrome_val = 1'b0;
      bus.irdy          = 1'b1;
      ireset_n          = 1'b1;
      tick();

      // basic frame and first-beat latency
      send(16'h4321, 1'b1);
      check("latency_val_sop", {bus.oval, bus.osop}, 2'b11);
      drain("drain_basic");

      // backpressure on beat 2
      send(16'h4321, 1'b1);
      tick();
      bus.irdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("stall_hold", {bus.oval, bus.osyndrome}, {1'b1, 4'h2});
         if (i < 2) tick();
      end
      bus.irdy = 1'b1;
      drain("drain_stall");

      // overflow: third frame dropped
      bus.irdy = 1'b0;
      send(16'h1111, 1'b1);
      check("ovf_f1", bus.ooverflow, 0);
      send(16'h2222, 1'b1);
      check("ovf_f2", bus.ooverflow, 0);
      send(16'h3333, 1'b0);
      check("ovf_pulse", bus.ooverflow, 1);
      tick();
      check("ovf_clear", bus.ooverflow, 0);
      bus.irdy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("ovf_no_gap", bus.oval, 1);
         tick();
      end
      check("ovf_done", bus.oval, 0);
      drain("drain_ovf");

      // write on free: new frame arrives during last beat of A with both slots full
      bus.irdy = 1'b0;
      send(16'hA987, 1'b1);
      send(16'hB654, 1'b1);
      bus.irdy = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (bus.oeop) found = 1'b1;
         else tick();
      end
      check("wof_last_beat_found", found, 1);
      send(16'h5555, 1'b1);
      check("wof_no_ovf", bus.ooverflow, 0);
      drain("drain_wof");

      // zero frame followed by a normal frame
      send(16'h0000, 1'b1);
      check("zero_first", {bus.oval, bus.osop, bus.ozero}, 3'b111);
      send(16'h4321, 1'b1);
`ifdef BCH_SYNDROME_COLLECT_ZERO_SKIP_EN
      check("zero_skip_next_sop", {bus.oval, bus.osop, bus.osyndrome}, {2'b11, 4'h1});
`else
      check("zero_beat2", {bus.oval, bus.osop, bus.ozero, bus.osyndrome}, {3'b101, 4'h0});
`endif
      drain("drain_zero");

      // asynchronous reset during beat 2
      send(16'h4321, 1'b1);
      tick();
      #2;
      ireset_n = 1'b0;
      #1;
      check("async_rst_oval", bus.oval, 0);
      check("async_rst_osop", bus.osop, 0);
      q.delete();
      @(posedge iclk);
      #1;
      ireset_n = 1'b1;
      tick();
      send(16'h8765, 1'b1);
      check("post_rst_sop", {bus.oval, bus.osop, bus.osyndrome}, {2'b11, 4'h5});
      drain("drain_post_rst");

      check("queue_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
